// File: rtl/usb3_hp_crc_arb.sv
// usb3_hp_crc_arb: round-robin share of one header-packet CRC-16 engine between two requesters
module usb3_hp_crc_arb #(
  parameter bit INVERT_OUT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [95:0] hdr0,
  output logic        ack0,
  input  logic        req1,
  input  logic [95:0] hdr1,
  output logic        ack1,
  output logic [15:0] crc_out,
  output logic        busy,
  output logic        gnt,
  output logic        eng_rst,
  output logic        eng_en,
  output logic [31:0] eng_d,
  input  logic [15:0] eng_crc
);
  typedef enum logic [2:0] {IDLE, INIT, DW0, DW1, DW2, DONE} state_t;
  state_t state, state_nx;
  logic gnt_nx;
  logic [1:0] req;
  logic [95:0] hdr;
  assign req = {req1, req0};
  assign hdr = gnt_nx ? hdr1 : hdr0;
  // The engine result only settles once DW2 has been clocked in, so the ack register gates it through here.
  assign crc_out = (ack0 | ack1) ? eng_crc ^ {16{INVERT_OUT}} : 16'h0000;
  // Next state: round-robin grant in IDLE, abort when the granted requester withdraws before DONE.
  always_comb begin
    state_nx = state;
    gnt_nx = gnt;
    case (state)
      IDLE: if (req0 | req1) begin
        gnt_nx = req[~gnt] ? ~gnt : gnt;
        state_nx = INIT;
      end
      INIT: state_nx = req[gnt] ? DW0 : IDLE;
      DW0: state_nx = req[gnt] ? DW1 : IDLE;
      DW1: state_nx = req[gnt] ? DW2 : IDLE;
      DW2: state_nx = req[gnt] ? DONE : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // State and all engine/handshake outputs registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt <= 1'b1;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      busy <= 1'b0;
      eng_rst <= 1'b0;
      eng_en <= 1'b0;
      eng_d <= 32'h0;
    end else begin
      state <= state_nx;
      gnt <= gnt_nx;
      ack0 <= state_nx == DONE && !gnt_nx;
      ack1 <= state_nx == DONE && gnt_nx;
      busy <= state_nx != IDLE;
      eng_rst <= state_nx == INIT;
      eng_en <= state_nx == DW0 || state_nx == DW1 || state_nx == DW2;
      eng_d <= state_nx == DW0 ? hdr[31:0] : state_nx == DW1 ? hdr[63:32] : state_nx == DW2 ? hdr[95:64] : 32'h0;
    end
  end
endmodule
